// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between N_REQ requesters, with a one-entry response register.
// Optional grant lock for back-to-back dependent operations is enabled with ALU_ARB_LOCK_EN.
module alu_arbiter #(
  parameter int unsigned N_REQ = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [4*N_REQ-1:0]    req_op,
  input  logic [32*N_REQ-1:0]   req_a,
  input  logic [32*N_REQ-1:0]   req_b,
  input  logic [N_REQ-1:0]      req_lock,
  output logic [3:0]            alu_op,
  output logic [31:0]           alu_a,
  output logic [31:0]           alu_b,
  input  logic [31:0]           alu_y,
  output logic [N_REQ-1:0]      rsp_valid,
  input  logic [N_REQ-1:0]      rsp_ready,
  output logic [31:0]           rsp_y
);
  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  typedef logic [IW-1:0] idx_t;

  logic        rsp_full;
  idx_t        owner;
  logic [31:0] y;
  idx_t        prio_ptr;
  logic        space;
  logic        found;
  idx_t        gidx;
  int unsigned s;
  logic        lock_hold;
  idx_t        lock_idx;

`ifdef ALU_ARB_LOCK_EN
  logic lock_active;
  // A lock whose owner has dropped req_valid no longer restricts arbitration.
  assign lock_hold = lock_active && req_valid[lock_idx];
`else
  logic unused_lock;
  assign lock_hold   = 1'b0;
  assign lock_idx    = '0;
  assign unused_lock = ^req_lock;
`endif

  assign space = !rsp_full || rsp_ready[owner];

  always_comb begin
    req_ready = '0;
    gidx      = prio_ptr;
    found     = 1'b0;
    s         = 0;
    if (!reset && space) begin
      if (lock_hold) begin
        gidx  = lock_idx;
        found = 1'b1;
      end else begin
        for (int unsigned k = 0; k < N_REQ; k++) begin
          s = 32'(prio_ptr) + k;
          if (s >= N_REQ) s = s - N_REQ;
          if (!found && req_valid[idx_t'(s)]) begin
            found = 1'b1;
            gidx  = idx_t'(s);
          end
        end
      end
      if (found) req_ready[gidx] = 1'b1;
    end
  end

  assign alu_op = req_op[32'(gidx)*4 +: 4];
  assign alu_a  = req_a[32'(gidx)*32 +: 32];
  assign alu_b  = req_b[32'(gidx)*32 +: 32];

  always_comb begin
    rsp_valid = '0;
    for (int unsigned i = 0; i < N_REQ; i++)
      rsp_valid[i] = rsp_full && (owner == idx_t'(i));
  end
  assign rsp_y = y;

  // Accepting in the same cycle as consumption overwrites the register, so there is no bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_full <= 1'b0;
      owner    <= '0;
      y        <= '0;
      prio_ptr <= '0;
    end else if (found) begin
      rsp_full <= 1'b1;
      owner    <= gidx;
      y        <= alu_y;
      prio_ptr <= (gidx == idx_t'(N_REQ-1)) ? '0 : gidx + 1'b1;
    end else if (rsp_full && rsp_ready[owner]) begin
      rsp_full <= 1'b0;
    end
  end

`ifdef ALU_ARB_LOCK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_active <= 1'b0;
      lock_idx    <= '0;
    end else if (found) begin
      lock_active <= req_lock[gidx];
      lock_idx    <= gidx;
    end else if (space && lock_active && !req_valid[lock_idx]) begin
      lock_active <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter: a 2-requester and a 3-requester instance, each driven by a small ALU model.
module tb_alu_arbiter;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLL = 4'd2, OP_SLT = 4'd3,
                         OP_SLTU = 4'd4, OP_XOR = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
                         OP_OR = 4'd8, OP_AND = 4'd9;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]  rv2, rr2, lk2, sv2, sr2;
  logic [7:0]  op2;
  logic [63:0] a2, b2;
  logic [3:0]  aop2;
  logic [31:0] aa2, ab2, ay2, sy2;

  logic [2:0]  rv3, rr3, lk3, sv3, sr3;
  logic [11:0] op3;
  logic [95:0] a3, b3;
  logic [3:0]  aop3;
  logic [31:0] aa3, ab3, ay3, sy3;

  function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLL:  return a << b[4:0];
      OP_SLT:  return {31'b0, $signed(a) < $signed(b)};
      OP_SLTU: return {31'b0, a < b};
      OP_XOR:  return a ^ b;
      OP_SRL:  return a >> b[4:0];
      OP_SRA:  return 32'($signed(a) >>> b[4:0]);
      OP_OR:   return a | b;
      OP_AND:  return a & b;
      default: return 32'd0;
    endcase
  endfunction

  always_comb ay2 = alu(aop2, aa2, ab2);
  always_comb ay3 = alu(aop3, aa3, ab3);

  alu_arbiter #(.N_REQ(2)) u_dut2 (
    .clk(clk), .reset(reset), .req_valid(rv2), .req_ready(rr2), .req_op(op2),
    .req_a(a2), .req_b(b2), .req_lock(lk2), .alu_op(aop2), .alu_a(aa2), .alu_b(ab2),
    .alu_y(ay2), .rsp_valid(sv2), .rsp_ready(sr2), .rsp_y(sy2)
  );

  alu_arbiter #(.N_REQ(3)) u_dut3 (
    .clk(clk), .reset(reset), .req_valid(rv3), .req_ready(rr3), .req_op(op3),
    .req_a(a3), .req_b(b3), .req_lock(lk3), .alu_op(aop3), .alu_a(aa3), .alu_b(ab3),
    .alu_y(ay3), .rsp_valid(sv3), .rsp_ready(sr3), .rsp_y(sy3)
  );

  int total = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set2(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    op2[4*i +: 4]  = op;
    a2[32*i +: 32] = a;
    b2[32*i +: 32] = b;
  endtask

  task automatic set3(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    op3[4*i +: 4]  = op;
    a3[32*i +: 32] = a;
    b3[32*i +: 32] = b;
  endtask

  logic [1:0] exp_g [4];
  int b1;

  initial begin
`ifdef ALU_ARB_LOCK_EN
    exp_g = '{2'b10, 2'b10, 2'b10, 2'b01};
`else
    exp_g = '{2'b10, 2'b01, 2'b10, 2'b01};
`endif
    reset = 1'b1;
    rv2 = 2'b11; sr2 = '0; lk2 = '0; op2 = '0; a2 = '0; b2 = '0;
    rv3 = 3'b111; sr3 = '0; lk3 = '0; op3 = '0; a3 = '0; b3 = '0;
    step();
    step();
    chk("reset_req_ready", rr2, 2'b00);
    chk("reset_rsp_valid", sv2, 2'b00);
    chk("reset_rsp_y", sy2, 32'd0);
    chk("reset_req_ready3", rr3, 3'b000);
    reset = 1'b0;
    rv2 = '0; rv3 = '0;
    step();

    // single op and response hold
    rv2 = 2'b01; set2(0, OP_ADD, 32'd5, 32'd7);
    #1;
    chk("single_grant", rr2, 2'b01);
    chk("single_alu_a", aa2, 32'd5);
    step();
    chk("single_rsp_valid", sv2, 2'b01);
    chk("single_rsp_y", sy2, 32'd12);
    rv2 = 2'b10; set2(1, OP_XOR, 32'hF0, 32'h0F);
    repeat (3) begin
      #1;
      chk("hold_no_grant", rr2, 2'b00);
      step();
      chk("hold_rsp_y", sy2, 32'd12);
      chk("hold_rsp_valid", sv2, 2'b01);
    end
    sr2 = 2'b01;
    #1;
    chk("consume_accept_grant", rr2, 2'b10);
    step();
    chk("consume_accept_valid", sv2, 2'b10);
    chk("consume_accept_y", sy2, 32'hFF);
    rv2 = '0; sr2 = 2'b11;
    step();
    chk("drain_valid", sv2, 2'b00);

    // fairness with immediate consumption
    rv2 = 2'b11; set2(0, OP_SUB, 32'd10, 32'd3); set2(1, OP_SLL, 32'd1, 32'd4);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_grant", rr2, (i % 2 == 1) ? 2'b10 : 2'b01);
      step();
      chk("rr_rsp_y", sy2, (i % 2 == 1) ? 32'd16 : 32'd7);
      chk("rr_rsp_valid", sv2, (i % 2 == 1) ? 2'b10 : 2'b01);
    end
    rv2 = '0;
    step();
    chk("rr_drain", sv2, 2'b00);

    // response stall blocks other requesters
    rv2 = 2'b10; set2(1, OP_SRA, 32'h8000_0000, 32'd30); sr2 = '0;
    #1;
    chk("stall_first_grant", rr2, 2'b10);
    step();
    chk("stall_rsp_y", sy2, 32'hFFFF_FFFE);
    chk("stall_rsp_valid", sv2, 2'b10);
    rv2 = 2'b01; set2(0, OP_ADD, 32'd5, 32'd7);
    repeat (2) begin
      #1;
      chk("stall_blocked", rr2, 2'b00);
      step();
    end
    sr2 = 2'b10;
    #1;
    chk("stall_release_grant", rr2, 2'b01);
    step();
    chk("stall_overwrite_valid", sv2, 2'b01);
    chk("stall_overwrite_y", sy2, 32'd12);
    rv2 = '0; sr2 = 2'b01;
    step();
    chk("stall_drain", sv2, 2'b00);

    // lock (grant sequence depends on ALU_ARB_LOCK_EN)
    rv2 = 2'b11; sr2 = 2'b11; set2(0, OP_SUB, 32'd10, 32'd3); set2(1, OP_ADD, 32'd1, 32'd1);
    b1 = 0;
    for (int c = 0; c < 4; c++) begin
      lk2 = {(b1 < 2), 1'b0};
      #1;
      chk("lock_grant", rr2, exp_g[c]);
      step();
      chk("lock_rsp_y", sy2, (exp_g[c] == 2'b10) ? 32'd2 : 32'd7);
      if (exp_g[c] == 2'b10) b1++;
    end
    rv2 = '0; lk2 = '0;
    step();

    // reset in the middle of operation
    rv2 = 2'b01; set2(0, OP_SUB, 32'd10, 32'd3); sr2 = '0;
    #1;
    chk("midreset_pre_grant", rr2, 2'b01);
    step();
    chk("midreset_pre_valid", sv2, 2'b01);
    rv2 = 2'b11;
    reset = 1'b1;
    #1;
    chk("midreset_ready_gated", rr2, 2'b00);
    step();
    chk("midreset_valid", sv2, 2'b00);
    chk("midreset_y", sy2, 32'd0);
    chk("midreset_ready", rr2, 2'b00);
    reset = 1'b0;
    #1;
    chk("midreset_first_grant", rr2, 2'b01);
    step();
    chk("midreset_post_y", sy2, 32'd7);
    chk("midreset_post_valid", sv2, 2'b01);
    rv2 = '0; sr2 = 2'b11;
    step();

    // wrap and re-grant, N_REQ=3
    rv3 = 3'b100; set3(2, OP_SLTU, 32'd1, 32'd2); sr3 = 3'b111;
    #1;
    chk("wrap_first_grant", rr3, 3'b100);
    step();
    chk("wrap_rsp_y", sy3, 32'd1);
    chk("wrap_rsp_valid", sv3, 3'b100);
    #1;
    chk("wrap_regrant", rr3, 3'b100);
    step();
    chk("wrap_regrant_y", sy3, 32'd1);
    rv3 = 3'b101; set3(0, OP_OR, 32'h30, 32'h05);
    #1;
    chk("wrap_req0_first", rr3, 3'b001);
    step();
    chk("wrap_req0_y", sy3, 32'h35);
    chk("wrap_req0_valid", sv3, 3'b001);
    rv3 = 3'b100;
    #1;
    chk("wrap_req2_next", rr3, 3'b100);
    step();
    chk("wrap_req2_y", sy3, 32'd1);
    rv3 = '0;
    step();
    chk("wrap_drain", sv3, 3'b000);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
